fsquare_iter: RTL

Iterative single-precision squarer, y = x*x. It is the inverse-direction companion of the table-based fsqrt pipeline and sits beside it in the FPU. The verification harness uses it to check sqrt results by re-squaring them, and the core can use it for x^2 without occupying fmul. The mantissa product is built with a radix-2^RADIX_BITS shift-add multiplier under a small FSM, with valid/ready handshakes on both sides.

---
 rtl/fsquare_iter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fsquare_iter.sv
// -----------------------------------------------------------------------------
// fsquare_iter : iterative IEEE-754 single-precision squarer, y = x*x.
//
// The 24x24 mantissa product is accumulated by a radix-2^RADIX_BITS shift-add
// multiplier: one RADIX_BITS-wide digit of the mantissa (LSB first) is consumed
// per CALC cycle, so a full product takes N = 24/RADIX_BITS cycles. One further
// cycle normalises, rounds (half-up on the guard bit) and packs the result.
//
// Parameters
//   RADIX_BITS : digit width per CALC cycle (1, 2, 3, 4, 6, 8, 12 or 24).
//
// Ports
//   clk       : clock, rising edge active
//   rstn      : asynchronous active-low reset
//   in_valid  : operand x valid
//   in_ready  : block can accept an operand
//   x         : IEEE-754 single operand (sign is ignored)
//   out_valid : result y valid (held until out_ready)
//   out_ready : consumer takes y
//   y         : IEEE-754 single result, sign always 0
//
// Build option
//   FSQUARE_DONE_BYPASS_EN : when defined, a new operand may be accepted on the
//   same edge that the finished result is consumed (DONE -> CALC directly).
// -----------------------------------------------------------------------------
module fsquare_iter #(
    parameter int RADIX_BITS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    localparam int N = 24 / RADIX_BITS;
    localparam logic [4:0] LAST_DIGIT = 5'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        C_NORM = 2'd0,
        C_ZERO = 2'd1,
        C_INF  = 2'd2,
        C_NAN  = 2'd3
    } cls_t;

    state_t      r_state;
    cls_t        r_cls;
    logic [7:0]  r_exp;
    logic [23:0] r_mplier;   // remaining multiplier digits, LSB digit next
    logic [47:0] r_mcand;    // multiplicand pre-shifted to the current digit
    logic [47:0] r_acc;      // partial product accumulator P
    logic [4:0]  r_cnt;
    logic [31:0] r_y;
    logic        r_out_valid;

    logic [31:0] w_abs_x;
    cls_t        w_x_cls;
    logic        w_accept;
    logic [47:0] w_pp;
    logic        w_norm_hi;
    logic [22:0] w_frac;
    logic        w_guard;
    logic [9:0]  w_exp_pre;
    logic [32:0] w_rounded;
    logic [9:0]  w_exp_fin;
    logic [31:0] w_result;

    assign out_valid = r_out_valid;
    assign y         = r_y;

    // Ready to accept: only in IDLE, or also while the result is being taken.
    always_comb begin
`ifdef FSQUARE_DONE_BYPASS_EN
        in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
`else
        in_ready = (r_state == S_IDLE);
`endif
        w_accept = in_valid && in_ready;
    end

    // Classify the incoming operand by magnitude; the sign never matters.
    always_comb begin
        w_abs_x = x & 32'h7FFF_FFFF;
        if (w_abs_x < 32'h0080_0000) begin
            w_x_cls = C_ZERO;           // zero or denormal
        end else if (w_abs_x == 32'h7F80_0000) begin
            w_x_cls = C_INF;
        end else if (w_abs_x > 32'h7F80_0000) begin
            w_x_cls = C_NAN;
        end else begin
            w_x_cls = C_NORM;
        end
    end

    // Partial product of the multiplicand and the current digit.
    always_comb begin
        w_pp = r_mcand * {{(48 - RADIX_BITS){1'b0}}, r_mplier[RADIX_BITS-1:0]};
    end

    // Normalise, round half-up on the guard bit and pack (used in ROUND).
    always_comb begin
        w_norm_hi = r_acc[47];
        if (w_norm_hi) begin
            w_frac  = r_acc[46:24];
            w_guard = r_acc[23];
        end else begin
            w_frac  = r_acc[45:23];
            w_guard = r_acc[22];
        end
        // 2e - 127 + Eadj as a 10-bit two's complement value.
        w_exp_pre = {1'b0, r_exp, 1'b0} - 10'd127 + {9'd0, w_norm_hi};
        // Rounding increments {E,frac} so a mantissa carry bumps the exponent.
        w_rounded = {w_exp_pre, w_frac} + {32'd0, w_guard};
        w_exp_fin = w_rounded[32:23];
        case (r_cls)
            C_ZERO:  w_result = 32'h0000_0000;
            C_INF:   w_result = 32'h7F80_0000;
            C_NAN:   w_result = 32'h7FC0_0000;
            C_NORM: begin
                if (!w_exp_fin[9] && (w_exp_fin >= 10'd255)) begin
                    w_result = 32'h7F80_0000;
                end else if (w_exp_fin[9] || (w_exp_fin == 10'd0)) begin
                    w_result = 32'h0000_0000;
                end else begin
                    w_result = {1'b0, w_exp_fin[7:0], w_rounded[22:0]};
                end
            end
            default: w_result = 32'h0000_0000;
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cls       <= C_ZERO;
            r_exp       <= 8'd0;
            r_mplier    <= 24'd0;
            r_mcand     <= 48'd0;
            r_acc       <= 48'd0;
            r_cnt       <= 5'd0;
            r_y         <= 32'h0000_0000;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            // Capture a new operand (from IDLE, or from DONE when bypassing).
            r_state     <= S_CALC;
            r_cls       <= w_x_cls;
            r_exp       <= x[30:23];
            r_mplier    <= {1'b1, x[22:0]};
            r_mcand     <= {24'd0, 1'b1, x[22:0]};
            r_acc       <= 48'd0;
            r_cnt       <= 5'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_CALC: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << RADIX_BITS;
                    r_mplier <= r_mplier >> RADIX_BITS;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == LAST_DIGIT) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_ROUND: begin
                    r_y         <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
